// File: rtl/mii_pkg.sv
// Shared types and constants for the MII transmit MAC and its CRC helper.
// The ABORT state only exists when MII_TX_UNDERRUN_ER_EN is defined.
package mii_pkg;

  typedef enum logic [3:0] {
    IDLE,
    PRE,
    SFD,
    DLO,
    DHI,
    PAD_LO,
    PAD_HI,
    FCS,
`ifdef MII_TX_UNDERRUN_ER_EN
    ABORT,
`endif
    IFG
  } tx_state_e;

  localparam logic [3:0]  PREAMBLE_NIBBLE = 4'h5;
  localparam logic [3:0]  SFD_NIBBLE      = 4'hD;
  localparam logic [31:0] CRC_POLY        = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT        = 32'hFFFFFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mii_crc32_nib.sv
// One-nibble step of the reflected CRC-32; shared with the RX checker.
module mii_crc32_nib
  import mii_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [3:0]  nib,
  output logic [31:0] crc_next
);

  always_comb begin
    crc_next = crc ^ {28'd0, nib};
    for (int i = 0; i < 4; i++)
      crc_next = crc_next[0] ? ((crc_next >> 1) ^ CRC_POLY) : (crc_next >> 1);
  end

endmodule

// File: rtl/mii_tx_mac.sv
// MII transmit MAC: preamble/SFD, zero padding, CRC-32 FCS and inter-frame gap.
// Define MII_TX_UNDERRUN_ER_EN to signal underruns on the wire with TX_ER.
module mii_tx_mac
  import mii_pkg::*;
#(
  parameter int PREAMBLE_NIB = 15,
  parameter int MIN_FRAME    = 60,
  parameter int IFG_NIB      = 24
) (
  input  logic        sig_MII_TX_CLK,
  input  logic        sig_RESET,
  input  logic [7:0]  sig_TX_DATA_IN,
  input  logic        sig_TX_VALID,
  input  logic        sig_TX_LAST,
  output logic        sig_TX_READY,
  output logic        sig_MII_TX_EN,
  output logic [3:0]  sig_MII_TX_DATA,
  output logic        sig_MII_TX_ER,
  output logic        sig_TX_DONE,
  output logic        sig_TX_UNDERRUN,
  output logic [15:0] sig_TX_BYTES
);

  localparam logic [7:0]  PRE_END = 8'(PREAMBLE_NIB);
  localparam logic [7:0]  IFG_END = 8'(IFG_NIB - 1);
  localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME);

  tx_state_e   state;
  logic [7:0]  ncnt;
  logic [15:0] byte_cnt;
  logic [7:0]  byte_q;
  logic        last_q;
  logic [31:0] crc;
  logic [31:0] crc_upd;

  // CRC absorbs whatever nibble is on the wire this cycle
  mii_crc32_nib u_crc (
    .crc      (crc),
    .nib      (sig_MII_TX_DATA),
    .crc_next (crc_upd)
  );

`ifndef MII_TX_UNDERRUN_ER_EN
  assign sig_MII_TX_ER = 1'b0;
`endif

  always_ff @(posedge sig_MII_TX_CLK) begin
    if (sig_RESET) begin
      state           <= IFG;
      ncnt            <= '0;
      byte_cnt        <= '0;
      byte_q          <= '0;
      last_q          <= 1'b0;
      crc             <= CRC_INIT;
      sig_TX_READY    <= 1'b0;
      sig_MII_TX_EN   <= 1'b0;
      sig_MII_TX_DATA <= '0;
      sig_TX_DONE     <= 1'b0;
      sig_TX_UNDERRUN <= 1'b0;
      sig_TX_BYTES    <= '0;
`ifdef MII_TX_UNDERRUN_ER_EN
      sig_MII_TX_ER   <= 1'b0;
`endif
    end else begin
      sig_TX_DONE     <= 1'b0;
      sig_TX_UNDERRUN <= 1'b0;
      case (state)
        IDLE: if (sig_TX_VALID && sig_TX_READY) begin
          byte_q          <= sig_TX_DATA_IN;
          last_q          <= sig_TX_LAST;
          byte_cnt        <= 16'd1;
          crc             <= CRC_INIT;
          ncnt            <= 8'd1;
          sig_TX_READY    <= 1'b0;
          sig_MII_TX_EN   <= 1'b1;
          sig_MII_TX_DATA <= PREAMBLE_NIBBLE;
          state           <= PRE;
        end
        PRE: begin
          if (ncnt == PRE_END) begin
            sig_MII_TX_DATA <= SFD_NIBBLE;
            state           <= SFD;
          end else begin
            ncnt <= ncnt + 8'd1;
          end
        end
        SFD: begin
          sig_MII_TX_DATA <= byte_q[3:0];
          state           <= DLO;
        end
        DLO: begin
          crc             <= crc_upd;
          sig_MII_TX_DATA <= byte_q[7:4];
          sig_TX_READY    <= !last_q;
          state           <= DHI;
        end
        DHI: begin
          crc          <= crc_upd;
          sig_TX_READY <= 1'b0;
          if (!last_q) begin
            if (sig_TX_VALID) begin
              byte_q          <= sig_TX_DATA_IN;
              last_q          <= sig_TX_LAST;
              byte_cnt        <= sat_inc16(byte_cnt);
              sig_MII_TX_DATA <= sig_TX_DATA_IN[3:0];
              state           <= DLO;
            end else begin
              sig_TX_UNDERRUN <= 1'b1;
              sig_MII_TX_DATA <= '0;
              ncnt            <= 8'd1;
`ifdef MII_TX_UNDERRUN_ER_EN
              sig_MII_TX_ER   <= 1'b1;
              state           <= ABORT;
`else
              sig_MII_TX_EN   <= 1'b0;
              state           <= IFG;
`endif
            end
          end else if (byte_cnt < MIN_LEN) begin
            byte_cnt        <= sat_inc16(byte_cnt);
            sig_MII_TX_DATA <= '0;
            state           <= PAD_LO;
          end else begin
            sig_MII_TX_DATA <= ~crc_upd[3:0];
            crc             <= {4'h0, ~crc_upd[31:4]};
            ncnt            <= 8'd1;
            state           <= FCS;
          end
        end
        PAD_LO: begin
          crc             <= crc_upd;
          sig_MII_TX_DATA <= '0;
          state           <= PAD_HI;
        end
        PAD_HI: begin
          crc <= crc_upd;
          if (byte_cnt < MIN_LEN) begin
            byte_cnt        <= sat_inc16(byte_cnt);
            sig_MII_TX_DATA <= '0;
            state           <= PAD_LO;
          end else begin
            sig_MII_TX_DATA <= ~crc_upd[3:0];
            crc             <= {4'h0, ~crc_upd[31:4]};
            ncnt            <= 8'd1;
            state           <= FCS;
          end
        end
        // crc now holds the remaining inverted FCS nibbles, shifted out LSB first
        FCS: begin
          if (ncnt == 8'd8) begin
            sig_MII_TX_EN   <= 1'b0;
            sig_MII_TX_DATA <= '0;
            ncnt            <= 8'd1;
            state           <= IFG;
          end else begin
            sig_MII_TX_DATA <= crc[3:0];
            crc             <= crc >> 4;
            ncnt            <= ncnt + 8'd1;
            if (ncnt == 8'd7) begin
              sig_TX_DONE  <= 1'b1;
              sig_TX_BYTES <= byte_cnt;
            end
          end
        end
`ifdef MII_TX_UNDERRUN_ER_EN
        ABORT: begin
          if (ncnt == 8'd2) begin
            sig_MII_TX_EN <= 1'b0;
            sig_MII_TX_ER <= 1'b0;
            ncnt          <= 8'd1;
            state         <= IFG;
          end else begin
            ncnt <= ncnt + 8'd1;
          end
        end
`endif
        // Frames re-enter with one gap nibble pre-counted: the IDLE cycle that
        // accepts the next byte is the final gap nibble. Reset starts from zero.
        IFG: begin
          if (ncnt >= IFG_END) begin
            sig_TX_READY <= 1'b1;
            state        <= IDLE;
          end else begin
            ncnt <= ncnt + 8'd1;
          end
        end
        default: state <= IFG;
      endcase
    end
  end

endmodule

// File: tb/tb_mii_tx_mac.sv
// Self-checking bench for mii_tx_mac: randomized frames against a nibble-stream model.
module tb_mii_tx_mac;

  typedef logic [3:0] nib_q_t[$];
  typedef logic [7:0] byte_q_t[$];
  typedef bit         bit_q_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data = 8'h00;
  logic        valid = 1'b0;
  logic        last = 1'b0;

  logic        rdy0, en0, er0, done0, und0;
  logic [3:0]  txd0;
  logic [15:0] bytes0;
  logic        rdy1, en1, er1, done1, und1;
  logic [3:0]  txd1;
  logic [15:0] bytes1;

  int n_pass = 0;
  int n_checks = 0;

  bit         cap_en[$];
  bit         cap_er[$];
  bit         cap_done[$];
  bit         cap_und[$];
  bit         cap_rdy[$];
  logic [3:0] cap_d[$];

  always #5 clk = ~clk;

  mii_tx_mac u_dut (
    .sig_MII_TX_CLK(clk), .sig_RESET(rst), .sig_TX_DATA_IN(data),
    .sig_TX_VALID(valid), .sig_TX_LAST(last), .sig_TX_READY(rdy0),
    .sig_MII_TX_EN(en0), .sig_MII_TX_DATA(txd0), .sig_MII_TX_ER(er0),
    .sig_TX_DONE(done0), .sig_TX_UNDERRUN(und0), .sig_TX_BYTES(bytes0)
  );

  mii_tx_mac #(.MIN_FRAME(0)) u_dut_nopad (
    .sig_MII_TX_CLK(clk), .sig_RESET(rst), .sig_TX_DATA_IN(data),
    .sig_TX_VALID(valid), .sig_TX_LAST(last), .sig_TX_READY(rdy1),
    .sig_MII_TX_EN(en1), .sig_MII_TX_DATA(txd1), .sig_MII_TX_ER(er1),
    .sig_TX_DONE(done1), .sig_TX_UNDERRUN(und1), .sig_TX_BYTES(bytes1)
  );

  // Wire image of one frame: preamble, SFD, padded payload, FCS (bytewise CRC)
  function automatic nib_q_t exp_nibbles(input byte_q_t pl, input int minf);
    nib_q_t      q;
    byte_q_t     b = pl;
    logic [31:0] c = 32'hFFFFFFFF;
    logic [31:0] fcs;
    while (b.size() < minf) b.push_back(8'h00);
    repeat (15) q.push_back(4'h5);
    q.push_back(4'hD);
    foreach (b[i]) begin
      q.push_back(b[i][3:0]);
      q.push_back(b[i][7:4]);
      c = c ^ {24'd0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    fcs = ~c;
    for (int k = 0; k < 8; k++) q.push_back(fcs[4*k +: 4]);
    return q;
  endfunction

  function automatic bit rdy(input bit sel);
    return sel ? rdy1 : rdy0;
  endfunction

  function automatic int count_ones(input bit_q_t q, input int a, input int b);
    int n = 0;
    for (int i = a; i < b && i < q.size(); i++) if (q[i]) n++;
    return n;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; valid = 1'b0; last = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive(input bit sel, input byte_q_t bq, input bit_q_t lq, input int stop_at);
    int i = 0;
    int c = 0;
    while (i < bq.size() && i != stop_at && c < 2000) begin
      @(negedge clk);
      c++;
      valid = 1'b1; data = bq[i]; last = lq[i];
      if (rdy(sel)) i++;
    end
    @(negedge clk);
    valid = 1'b0; last = 1'b0;
  endtask

  task automatic capture(input bit sel, input int n);
    cap_en.delete(); cap_er.delete(); cap_done.delete();
    cap_und.delete(); cap_rdy.delete(); cap_d.delete();
    repeat (n) begin
      @(negedge clk);
      cap_en.push_back(sel ? en1 : en0);
      cap_er.push_back(sel ? er1 : er0);
      cap_done.push_back(sel ? done1 : done0);
      cap_und.push_back(sel ? und1 : und0);
      cap_rdy.push_back(sel ? rdy1 : rdy0);
      cap_d.push_back(sel ? txd1 : txd0);
    end
  endtask

  task automatic frame_stats(input int from, input nib_q_t exp, output int s, output int len,
                             output int bad, output int dcnt, output int dat);
    s = -1; len = 0; bad = 0; dcnt = 0; dat = -1;
    for (int i = from; i < cap_en.size(); i++) if (cap_en[i]) begin s = i; break; end
    if (s < 0) return;
    for (int i = s; i < cap_en.size() && cap_en[i]; i++) begin
      len++;
      if (len <= exp.size() && cap_d[i] !== exp[len-1]) bad++;
      if (cap_done[i]) begin dcnt++; dat = i - s; end
    end
  endtask

  task automatic test_reset();
    int c = 0;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if ({en0, er0, rdy0, done0, und0} !== 5'b0) $display("FAIL reset_ctrl: got %b, expected 00000", {en0, er0, rdy0, done0, und0}); else n_pass++;
    n_checks++; if (txd0 !== 4'h0) $display("FAIL reset_txd: got %0h, expected 0", txd0); else n_pass++;
    n_checks++; if (bytes0 !== 16'd0) $display("FAIL reset_bytes: got %0d, expected 0", bytes0); else n_pass++;
    n_checks++; if ({en1, rdy1, txd1} !== 6'b0) $display("FAIL reset_nopad: got %b, expected 0", {en1, rdy1, txd1}); else n_pass++;
    rst = 1'b0; valid = 1'b1; data = 8'h3C; last = 1'b1;
    while (!rdy0 && c < 100) begin @(negedge clk); c++; end
    n_checks++; if (c !== 24) $display("FAIL ready_rise: got %0d cycles, expected 24", c); else n_pass++;
    @(negedge clk);
    valid = 1'b0; last = 1'b0;
    n_checks++; if ({en0, txd0} !== 5'b1_0101) $display("FAIL preamble_start: got en=%0d txd=%0h, expected en=1 txd=5", en0, txd0); else n_pass++;
  endtask

  task automatic test_crc_vector();
    byte_q_t     bq;
    bit_q_t      lq;
    nib_q_t      exp;
    int          s, len, bad, dcnt, dat, fbad;
    logic [31:0] fcs_ref = 32'hCBF43926;
    for (int i = 0; i < 9; i++) begin bq.push_back(8'h31 + 8'(i)); lq.push_back(i == 8); end
    exp = exp_nibbles(bq, 0);
    do_reset();
    fork
      drive(1'b1, bq, lq, -1);
      capture(1'b1, 120);
    join
    frame_stats(0, exp, s, len, bad, dcnt, dat);
    fbad = 0;
    for (int k = 0; k < 8; k++) if (s < 0 || cap_d[s+34+k] !== fcs_ref[4*k +: 4]) fbad++;
    n_checks++; if (len !== 42) $display("FAIL crc_len: got %0d, expected 42", len); else n_pass++;
    n_checks++; if (bad !== 0) $display("FAIL crc_nibbles: got %0d bad, expected 0", bad); else n_pass++;
    n_checks++; if (fbad !== 0) $display("FAIL crc_fcs_ref: got %0d bad, expected 0", fbad); else n_pass++;
    n_checks++; if (dat !== 41 || dcnt !== 1) $display("FAIL crc_done: got at %0d x%0d, expected at 41 x1", dat, dcnt); else n_pass++;
    n_checks++; if (bytes1 !== 16'd9) $display("FAIL crc_bytes: got %0d, expected 9", bytes1); else n_pass++;
  endtask

  task automatic test_pad_min();
    byte_q_t bq;
    bit_q_t  lq;
    nib_q_t  exp;
    int      s, len, bad, dcnt, dat;
    bq.push_back(8'hAA); lq.push_back(1'b1);
    exp = exp_nibbles(bq, 60);
    do_reset();
    fork
      drive(1'b0, bq, lq, -1);
      capture(1'b0, 200);
    join
    frame_stats(0, exp, s, len, bad, dcnt, dat);
    n_checks++; if (len !== 144) $display("FAIL pad_len: got %0d, expected 144", len); else n_pass++;
    n_checks++; if (bad !== 0) $display("FAIL pad_nibbles: got %0d bad, expected 0", bad); else n_pass++;
    n_checks++; if (dat !== 143) $display("FAIL pad_done: got %0d, expected 143", dat); else n_pass++;
    n_checks++; if (bytes0 !== 16'd60) $display("FAIL pad_bytes: got %0d, expected 60", bytes0); else n_pass++;
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      byte_q_t bq;
      bit_q_t  lq;
      nib_q_t  exp;
      int      s, len, bad, dcnt, dat, n, minf, tot;
      bit      sel = bit'(f % 2);
      minf = sel ? 0 : 60;
      n = $urandom_range(1, 80);
      for (int i = 0; i < n; i++) begin bq.push_back(8'($urandom)); lq.push_back(i == n - 1); end
      exp = exp_nibbles(bq, minf);
      tot = (n > minf) ? n : minf;
      do_reset();
      fork
        drive(sel, bq, lq, -1);
        capture(sel, exp.size() + 60);
      join
      frame_stats(0, exp, s, len, bad, dcnt, dat);
      n_checks++; if (len !== exp.size()) $display("FAIL rand_len f%0d: got %0d, expected %0d", f, len, exp.size()); else n_pass++;
      n_checks++; if (bad !== 0) $display("FAIL rand_nibbles f%0d: got %0d bad, expected 0", f, bad); else n_pass++;
      n_checks++; if (dcnt !== 1 || dat !== exp.size() - 1) $display("FAIL rand_done f%0d: got at %0d x%0d, expected at %0d x1", f, dat, dcnt, exp.size() - 1); else n_pass++;
      n_checks++; if ((sel ? bytes1 : bytes0) !== 16'(tot)) $display("FAIL rand_bytes f%0d: got %0d, expected %0d", f, sel ? bytes1 : bytes0, tot); else n_pass++;
      n_checks++; if (count_ones(cap_er, 0, cap_er.size()) !== 0) $display("FAIL rand_er f%0d: got %0d er cycles, expected 0", f, count_ones(cap_er, 0, cap_er.size())); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    byte_q_t bq, b1, b2;
    bit_q_t  lq;
    nib_q_t  e1, e2;
    int      s1, l1, bad1, d1, a1, s2, l2, bad2, d2, a2, gap, rg;
    for (int i = 0; i < 128; i++) begin
      bq.push_back(8'($urandom));
      lq.push_back(i == 63 || i == 127);
      if (i < 64) b1.push_back(bq[i]); else b2.push_back(bq[i]);
    end
    e1 = exp_nibbles(b1, 60);
    e2 = exp_nibbles(b2, 60);
    do_reset();
    fork
      drive(1'b0, bq, lq, -1);
      capture(1'b0, 420);
    join
    frame_stats(0, e1, s1, l1, bad1, d1, a1);
    frame_stats(s1 + l1, e2, s2, l2, bad2, d2, a2);
    gap = s2 - (s1 + l1);
    rg = count_ones(cap_rdy, s1 + l1, s2 - 1);
    n_checks++; if (l1 !== 152 || l2 !== 152) $display("FAIL b2b_len: got %0d/%0d, expected 152/152", l1, l2); else n_pass++;
    n_checks++; if (bad1 + bad2 !== 0) $display("FAIL b2b_nibbles: got %0d bad, expected 0", bad1 + bad2); else n_pass++;
    n_checks++; if (gap !== 24) $display("FAIL b2b_gap: got %0d, expected 24", gap); else n_pass++;
    n_checks++; if (rg !== 0) $display("FAIL b2b_ready_in_gap: got %0d, expected 0", rg); else n_pass++;
    n_checks++; if (d1 + d2 !== 2) $display("FAIL b2b_done: got %0d, expected 2", d1 + d2); else n_pass++;
    n_checks++; if (bytes0 !== 16'd64) $display("FAIL b2b_bytes: got %0d, expected 64", bytes0); else n_pass++;
  endtask

  task automatic test_underrun();
    byte_q_t bq;
    bit_q_t  lq;
    nib_q_t  exp;
    int      s, len, bad, dcnt, dat, ucnt, ecnt, exp_len;
    bit      upos;
    for (int i = 0; i < 64; i++) begin bq.push_back(8'($urandom)); lq.push_back(i == 63); end
    exp = exp_nibbles(bq, 60);
`ifdef MII_TX_UNDERRUN_ER_EN
    exp_len = 38;
`else
    exp_len = 36;
`endif
    do_reset();
    fork
      drive(1'b0, bq, lq, 10);
      capture(1'b0, 150);
    join
    frame_stats(0, exp, s, len, bad, dcnt, dat);
    if (s < 0) s = 0;
    bad = 0;
    for (int i = 0; i < 36; i++) if (cap_d[s+i] !== exp[i]) bad++;
    ucnt = count_ones(cap_und, 0, cap_und.size());
    ecnt = count_ones(cap_er, 0, cap_er.size());
    upos = cap_und[s+36];
    n_checks++; if (len !== exp_len) $display("FAIL und_len: got %0d, expected %0d", len, exp_len); else n_pass++;
    n_checks++; if (bad !== 0) $display("FAIL und_prefix: got %0d bad, expected 0", bad); else n_pass++;
    n_checks++; if (ucnt !== 1 || upos !== 1'b1) $display("FAIL und_pulse: got %0d pulses at_pos=%0d, expected 1 at_pos=1", ucnt, upos); else n_pass++;
    n_checks++; if (count_ones(cap_done, 0, cap_done.size()) !== 0) $display("FAIL und_no_done: got %0d, expected 0", count_ones(cap_done, 0, cap_done.size())); else n_pass++;
`ifdef MII_TX_UNDERRUN_ER_EN
    n_checks++; if (ecnt !== 2 || !cap_er[s+36] || !cap_er[s+37] || cap_d[s+36] !== 4'h0 || cap_d[s+37] !== 4'h0) $display("FAIL und_er: got %0d er cycles, expected 2 with txd 0", ecnt); else n_pass++;
`else
    n_checks++; if (ecnt !== 0) $display("FAIL und_er: got %0d er cycles, expected 0", ecnt); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid();
    int c = 0;
    int e = 0;
    do_reset();
    valid = 1'b1; data = 8'hA5; last = 1'b0;
    while (e < 19 && c < 200) begin @(negedge clk); c++; if (en0) e++; end
    n_checks++; if (e !== 19 || txd0 !== 4'h5) $display("FAIL mid_dlo: got en_cycles=%0d txd=%0h, expected 19 and 5", e, txd0); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if ({en0, er0, rdy0, done0, und0, txd0} !== 9'b0 || bytes0 !== 16'd0) $display("FAIL mid_reset_out: got %b bytes=%0d, expected 0", {en0, er0, rdy0, done0, und0, txd0}, bytes0); else n_pass++;
    c = 0;
    while (!en0 && c < 100) begin @(negedge clk); c++; end
    n_checks++; if (c < 24 || c >= 100) $display("FAIL mid_gap: got %0d idle cycles, expected >=24 and a restart", c); else n_pass++;
    valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_crc_vector();
    test_pad_min();
    test_random();
    test_back_to_back();
    test_underrun();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mii_tx_mac.md
Name: mii_tx_mac

Overview:
- Active MAC-side MII transmitter. It takes a byte stream with a valid/ready handshake and drives the MII TX pins of a 10/100 PHY.
- Per frame it inserts the preamble and SFD, pads the payload to the minimum frame length, appends the CRC-32 FCS, and enforces the inter-frame gap.
- It is the driving end of the TX half of the interface that the passive MII monitor observes. Bench and RTL share the TX pin names.

Parameters:
- PREAMBLE_NIB, 15, number of 0x5 preamble nibbles sent before the SFD nibble 0xD.
- MIN_FRAME, 60, minimum number of data bytes before the FCS; shorter frames are zero-padded up to this length.
- IFG_NIB, 24, idle nibble-times after each frame (96 bit times).

Ports:
- sig_MII_TX_CLK  in  1  MII transmit clock, 2.5/25 MHz; the only clock.
- sig_RESET  in  1  synchronous, active-high reset.
- sig_TX_DATA_IN  in  8  client byte.
- sig_TX_VALID  in  1  client byte valid.
- sig_TX_LAST  in  1  marks the final client byte of the frame.
- sig_TX_READY  out  1  byte accepted when valid && ready.
- sig_MII_TX_EN  out  1  MII transmit enable.
- sig_MII_TX_DATA  out  4  MII nibble, LSB nibble of each byte first.
- sig_MII_TX_ER  out  1  MII transmit error.
- sig_TX_DONE  out  1  one-cycle pulse when the last FCS nibble is driven.
- sig_TX_UNDERRUN  out  1  one-cycle pulse when an underrun is detected.
- sig_TX_BYTES  out  16  data+pad byte count of the last completed frame.

Behaviour:
- Single clock; synchronous active-high reset.
- Reset values: TX_EN=0, TX_DATA=0, TX_ER=0, TX_READY=0, TX_DONE=0, TX_UNDERRUN=0, TX_BYTES=0. State after reset is IFG with a full gap count, so the first frame cannot start for IFG_NIB cycles.
- All MII outputs are registered.
- States: IDLE, PRE, SFD, DLO, DHI, PAD_LO, PAD_HI, FCS, ABORT, IFG.
- IDLE: TX_READY=1. An accepted byte is latched and the FSM goes to PRE.
- PRE: TX_EN=1, TXD=0x5 for PREAMBLE_NIB cycles, then SFD.
- SFD: TXD=0xD for 1 cycle, then DLO.
- DLO: drive latched byte[3:0].
- DHI: drive latched byte[7:4].
  - TX_READY=1 in DHI only if the current byte is not LAST.
  - Accepted byte -> DLO next cycle. Gap-free: 1 byte per 2 cycles.
  - Current byte LAST: go to PAD_LO if byte count < MIN_FRAME, else FCS.
  - TX_READY=1 with TX_VALID=0 in DHI is an underrun.
- PAD_LO/PAD_HI: drive 0x0 nibbles, incrementing the byte count, until the count reaches MIN_FRAME; then FCS.
- CRC-32:
  - Reflected polynomial 0xEDB88320, init 0xFFFFFFFF, updated one nibble per cycle over data and pad nibbles only.
  - FCS = ~crc, sent as 8 nibbles, least-significant nibble first.
  - TX_DONE pulses on the 8th FCS nibble; TX_BYTES latches the byte count at the same time.
  - Next state IFG.
- IFG: TX_EN=0, TXD=0 for IFG_NIB cycles, TX_READY=0, then IDLE.
- Byte counter: 16 bits, saturating at 0xFFFF. No maximum-length check.
- TX_LAST accepted together with the first byte in IDLE is legal: 1-byte frame, padded.
- Reset in any state returns all outputs to reset values on the next edge. A partial frame is dropped with no FCS; the reset IFG still applies.
- TX_VALID/TX_LAST are ignored when TX_READY=0.

Optional Feature:
- Macro: MII_TX_UNDERRUN_ER_EN.
- Defined:
  - On underrun the FSM enters ABORT.
  - ABORT drives TX_EN=1, TX_ER=1, TXD=0 for 2 cycles; the FCS is not sent.
  - TX_UNDERRUN pulses on the first ABORT cycle; TX_DONE does not pulse.
  - Then IFG.
- Undefined:
  - TX_ER is tied 0 and the ABORT state is absent.
  - On underrun, TX_EN drops on the next cycle with no FCS, TX_UNDERRUN pulses, then IFG.
- In both cases the client must still drain the rest of the frame through the normal handshake.

Decomposition:
- Package mii_pkg holds:
  - state enum;
  - constants PREAMBLE_NIBBLE=4'h5, SFD_NIBBLE=4'hD, CRC_POLY=32'hEDB88320, CRC_INIT=32'hFFFFFFFF.
- Sub-module mii_crc32_nib: combinational next-CRC for one nibble. It is reused by the future RX checker.

Test Plan:
- MIN_FRAME=0, bytes "123456789" (0x31..0x39): 15x0x5, 0xD, 18 data nibbles 1,3,2,3,…,9,3, then FCS nibbles 6,2,9,3,4,F,B,C; TX_DONE on the last FCS nibble; TX_BYTES=9.
- Default params, 1-byte frame 0xAA with LAST: 60 bytes total on the wire, then 8 FCS nibbles, TX_EN high for 16+120+8=144 cycles; TX_BYTES=60.
- Two back-to-back 64-byte frames with VALID always high: exactly 24 TX_EN=0 cycles between frames; TX_READY low throughout the gap.
- VALID dropped at byte 10 of a 64-byte frame:
  - with macro, 2 cycles of TX_EN=1/TX_ER=1, then TX_EN=0, TX_UNDERRUN pulse, no TX_DONE;
  - without macro, TX_EN falls the next cycle and TX_ER stays 0.
- sig_RESET asserted for 1 cycle mid-DLO: all outputs 0 on the next edge, and no frame starts for 24 cycles after release.
- After reset, VALID held high: TX_READY first rises after 24 cycles, and the preamble starts the cycle after acceptance.
